exmem_skid_stage: RTL and testbench
===================================

EXMEM_SKID_STAGE -- requirements
Module: exmem_skid_stage

Interface
REQ-001 Parameters SHALL be: DATA_W, 32, width of the ALU result and reg2 fields.
REQ-002 Parameters SHALL be: NUM_THREADS, 4, hardware thread count; TID_W = clog2(NUM_THREADS), minimum 1.
REQ-003 Parameters SHALL be: CNT_W, 16, drop counter width.
REQ-004 The block SHALL have one clock; reset SHALL be synchronous and active-high.
REQ-005 Ports SHALL be:
 clk  in  1  clock, rising edge
 rst  in  1  synchronous active-high reset
 in_valid  in  1  upstream beat present
 in_ready  out  1  stage can accept a beat
 in_pkt  in  exmem_pkt_t  EX-stage payload with thread tag
 flush_valid  in  1  kill request
 flush_tid  in  TID_W  thread whose beats are killed
 out_valid  out  1  MEM-side beat present
 out_ready  in  1  MEM side consumes
 out_pkt  out  exmem_pkt_t  payload to MEM
 occupancy  out  2  stored beats, 0..2
 drop_count  out  CNT_W  beats killed by flush, saturating

Function
REQ-006 A beat SHALL transfer in when in_valid & in_ready, and out when out_valid & out_ready.
REQ-007 Storage SHALL be a main register, which drives out_pkt, plus one skid register.
REQ-008 The state SHALL be EMPTY, ONE (main only) or FULL (main+skid); occupancy SHALL be 0/1/2 respectively.
REQ-009 in_ready SHALL be a registered signal equal to (state != FULL) and SHALL NOT depend combinationally on out_ready.
REQ-010 out_valid SHALL equal (state != EMPTY) and SHALL NOT depend combinationally on in_valid.
REQ-011 Latency SHALL be one cycle: a beat accepted into EMPTY at edge N appears on out_pkt with out_valid after edge N.
REQ-012 ONE with push and pop SHALL load main from in_pkt and stay in ONE, sustaining one beat per cycle.
REQ-013 ONE with push and no pop SHALL load skid and move to FULL.
REQ-014 FULL with pop SHALL move skid to main and go to ONE; no push is possible in FULL.
REQ-015 Order SHALL be preserved: out beats leave in acceptance order.
REQ-016 On flush_valid, every stored beat with tid == flush_tid SHALL be invalidated at that edge, and an incoming beat with matching tid SHALL be accepted and discarded.
REQ-017 Flush SHALL take precedence over pop: a flushed main beat presented in the same cycle counts as consumed but is dropped from the count of delivered beats; MEM ignores it only via the flush signal it also receives.
REQ-018 If main is flushed and skid survives, skid SHALL move to main in the same edge; surviving non-matching beats SHALL keep their order.
REQ-019 Push, pop and flush in one cycle SHALL compose: flush first, then pop, then push into the lowest free slot.
REQ-020 drop_count SHALL add the number of beats killed per edge (0..3) and saturate at all-ones.
REQ-021 out_pkt SHALL hold its last value while out_valid is low.

Reset
REQ-022 On rst, state SHALL be EMPTY, occupancy 0, out_valid 0, in_ready 1, drop_count 0, and out_pkt and skid SHALL be all zeros.
REQ-023 Reset SHALL dominate flush, push and pop in the same cycle; beats in flight SHALL be discarded and not counted.

Structure
REQ-024 A shared package exmem_pkg SHALL hold exmem_pkt_t (alu[DATA_W], opcode[7], cond, instr[32], reg_dst[5], reg2[DATA_W], mem_write, alu_write, cmd_type[2], tid[TID_W]), the state enum, and the defaults.
REQ-025 Flush-match and kill-count logic SHALL be one sub-module, exmem_flush_match, which is purely combinational over the three candidate beats.

Verification
REQ-026 Reset then one beat with alu=0x12345678 and tid=1 -> out_valid on the next cycle, out_pkt.alu=0x12345678, occupancy=1.
REQ-027 10 back-to-back beats with out_ready=1 -> 10 beats out in order, in_ready stays 1, occupancy never 2.
REQ-028 out_ready=0 and 3 beats offered -> 2 accepted, in_ready=0, occupancy=2; out_ready=1 -> drains in order, third beat accepted one cycle later.
REQ-029 FULL with main tid=2 and skid tid=3, flush_tid=2 -> skid beat appears on out_pkt after one edge, occupancy=1, drop_count=1.
REQ-030 FULL with both tid=0, push of tid=0 and flush_tid=0 in the same cycle -> occupancy=0, drop_count=3.
REQ-031 drop_count forced near 0xFFFF and 3 kills -> holds 0xFFFF; rst asserted while FULL -> all outputs return to reset values after one edge.

Source files
------------

// File: rtl/exmem_pkg.sv
// Shared types for the EX/MEM skid stage: payload layout, stage state and
// reset defaults.
package exmem_pkg;

    localparam int unsigned EXMEM_DATA_W      = 32;
    localparam int unsigned EXMEM_NUM_THREADS = 4;
    localparam int unsigned EXMEM_TID_W       =
        (EXMEM_NUM_THREADS > 1) ? $clog2(EXMEM_NUM_THREADS) : 1;

    // EX-stage payload carried to MEM, tagged with its hardware thread.
    typedef struct packed {
        logic [EXMEM_DATA_W-1:0] alu;
        logic [6:0]              opcode;
        logic                    cond;
        logic [31:0]             instr;
        logic [4:0]              reg_dst;
        logic [EXMEM_DATA_W-1:0] reg2;
        logic                    mem_write;
        logic                    alu_write;
        logic [1:0]              cmd_type;
        logic [EXMEM_TID_W-1:0]  tid;
    } exmem_pkt_t;

    // Number of stored beats: EMPTY, main only, main plus skid.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } exmem_state_e;

    localparam exmem_pkt_t EXMEM_PKT_RESET = '0;

    // The state encoding doubles as the stored-beat count.
    function automatic logic [1:0] occupancy_of(input exmem_state_e s);
        return logic'(s == ST_FULL) ? 2'd2 : (s == ST_ONE) ? 2'd1 : 2'd0;
    endfunction

endpackage

// File: rtl/exmem_flush_match.sv
// Decides which of the three candidate beats (main, skid, incoming) a flush
// kills this cycle and how many that is.
module exmem_flush_match
    import exmem_pkg::*;
(
    input  logic                   i_flush_valid,
    input  logic [EXMEM_TID_W-1:0] i_flush_tid,
    input  logic                   i_main_valid,
    input  logic [EXMEM_TID_W-1:0] i_main_tid,
    input  logic                   i_skid_valid,
    input  logic [EXMEM_TID_W-1:0] i_skid_tid,
    input  logic                   i_in_valid,
    input  logic [EXMEM_TID_W-1:0] i_in_tid,
    output logic                   o_kill_main,
    output logic                   o_kill_skid,
    output logic                   o_kill_in,
    output logic [1:0]             o_kill_count
);

    // Tag-compare each present beat against the flushed thread.
    always_comb begin
        o_kill_main  = i_flush_valid & i_main_valid & (i_main_tid == i_flush_tid);
        o_kill_skid  = i_flush_valid & i_skid_valid & (i_skid_tid == i_flush_tid);
        o_kill_in    = i_flush_valid & i_in_valid   & (i_in_tid   == i_flush_tid);
        o_kill_count = {1'b0, o_kill_main} + {1'b0, o_kill_skid} + {1'b0, o_kill_in};
    end

endmodule

// File: rtl/exmem_skid_stage.sv
// EX/MEM pipeline register with a one-entry skid buffer so in_ready can be
// registered, plus per-thread flush with a saturating drop counter.
module exmem_skid_stage
    import exmem_pkg::*;
#(
    parameter int unsigned DATA_W      = EXMEM_DATA_W,
    parameter int unsigned NUM_THREADS = EXMEM_NUM_THREADS,
    parameter int unsigned CNT_W       = 16,
    localparam int unsigned TID_W      = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  exmem_pkt_t       in_pkt,
    input  logic             flush_valid,
    input  logic [TID_W-1:0] flush_tid,
    output logic             out_valid,
    input  logic             out_ready,
    output exmem_pkt_t       out_pkt,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] drop_count
);

    // The payload layout lives in the package, so the parameters must agree with it.
    if (DATA_W != EXMEM_DATA_W || TID_W != EXMEM_TID_W) begin : g_param_check
        $error("exmem_skid_stage: DATA_W/NUM_THREADS disagree with exmem_pkg");
    end

    exmem_state_e     r_state;
    exmem_state_e     w_state_next;
    exmem_pkt_t       r_main;
    exmem_pkt_t       r_skid;
    exmem_pkt_t       w_main_next;
    exmem_pkt_t       w_skid_next;
    logic             r_in_ready;
    logic [CNT_W-1:0] r_drop_count;
    logic [CNT_W-1:0] w_drop_next;
    logic [CNT_W:0]   w_drop_sum;

    logic             w_main_valid;
    logic             w_skid_valid;
    logic             w_kill_main;
    logic             w_kill_skid;
    logic             w_kill_in;
    logic [1:0]       w_kill_count;
    logic             w_push;
    logic             w_main_keep;
    logic             w_skid_keep;

    assign w_main_valid = (r_state != ST_EMPTY);
    assign w_skid_valid = (r_state == ST_FULL);

    // A matching incoming beat is killed whether or not we are ready: the
    // producer sees the same flush and drops it on its side as well.
    exmem_flush_match u_flush_match (
        .i_flush_valid (flush_valid),
        .i_flush_tid   (flush_tid),
        .i_main_valid  (w_main_valid),
        .i_main_tid    (r_main.tid),
        .i_skid_valid  (w_skid_valid),
        .i_skid_tid    (r_skid.tid),
        .i_in_valid    (in_valid),
        .i_in_tid      (in_pkt.tid),
        .o_kill_main   (w_kill_main),
        .o_kill_skid   (w_kill_skid),
        .o_kill_in     (w_kill_in),
        .o_kill_count  (w_kill_count)
    );

    // Flush first, then pop (a killed main is consumed by the pop it was shown
    // with), then push into the lowest free slot.
    assign w_push      = in_valid & r_in_ready & ~w_kill_in;
    assign w_main_keep = w_main_valid & ~w_kill_main & ~out_ready;
    assign w_skid_keep = w_skid_valid & ~w_kill_skid;

    // Next-state, storage compaction and saturating drop count.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
        w_state_next = ST_EMPTY;
        w_main_next  = r_main;
        w_skid_next  = r_skid;
        unique case ({w_main_keep, w_skid_keep})
            2'b11: begin
                // Only reachable from FULL, where in_ready is low.
                w_state_next = ST_FULL;
            end
            2'b10, 2'b01: begin
                if (w_skid_keep) begin
                    w_main_next = r_skid;
                end
                if (w_push) begin
                    w_skid_next  = in_pkt;
                    w_state_next = ST_FULL;
                end else begin
                    w_state_next = ST_ONE;
                end
            end
            default: begin
                if (w_push) begin
                    w_main_next  = in_pkt;
                    w_state_next = ST_ONE;
                end
            end
        endcase

        w_drop_sum  = {1'b0, r_drop_count} + (CNT_W+1)'(w_kill_count);
        w_drop_next = w_drop_sum[CNT_W] ? {CNT_W{1'b1}} : w_drop_sum[CNT_W-1:0];
    end

    // State, payload registers, registered in_ready and drop counter.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            r_state      <= ST_EMPTY;
            r_in_ready   <= 1'b1;
            // NOTE: payload registers are reset too, so out_pkt reads as zero after reset.
            r_main       <= EXMEM_PKT_RESET;
            r_skid       <= EXMEM_PKT_RESET;
            r_drop_count <= '0;
        end else begin
            r_state      <= w_state_next;
            r_in_ready   <= (w_state_next != ST_FULL);
            r_main       <= w_main_next;
            r_skid       <= w_skid_next;
            r_drop_count <= w_drop_next;
        end
    end

    assign in_ready   = r_in_ready;
    assign out_valid  = w_main_valid;
    assign out_pkt    = r_main;
    assign occupancy  = occupancy_of(r_state);
    assign drop_count = r_drop_count;

endmodule

// File: tb/tb_exmem_skid_stage.sv
// Self-checking bench for exmem_skid_stage: directed scenarios plus random
// traffic, checked against a queue-based model of the stage contents.
module tb_exmem_skid_stage;
    import exmem_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   rst;
    logic                   in_valid;
    exmem_pkt_t             in_pkt;
    logic                   flush_valid;
    logic [EXMEM_TID_W-1:0] flush_tid;
    logic                   out_ready;

    logic       in_ready,  in_ready_s;
    logic       out_valid, out_valid_s;
    exmem_pkt_t out_pkt,   out_pkt_s;
    logic [1:0] occupancy, occupancy_s;
    logic [15:0] drop_count;
    logic [1:0]  drop_count_s;

    exmem_skid_stage #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pkt(in_pkt),
        .flush_valid(flush_valid), .flush_tid(flush_tid), .out_valid(out_valid),
        .out_ready(out_ready), .out_pkt(out_pkt), .occupancy(occupancy), .drop_count(drop_count)
    );

    // Narrow counter copy so saturation is reachable in a short run.
    exmem_skid_stage #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s), .in_pkt(in_pkt),
        .flush_valid(flush_valid), .flush_tid(flush_tid), .out_valid(out_valid_s),
        .out_ready(out_ready), .out_pkt(out_pkt_s), .occupancy(occupancy_s), .drop_count(drop_count_s)
    );

    int checks   = 0;
    int failures = 0;

    // Model: ordered list of stored beats, total kills, last value shown on out_pkt.
    exmem_pkt_t m_q[$];
    int         m_drops = 0;
    exmem_pkt_t m_last  = '0;
    int         out_beats = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exmem_pkt_t mk(input logic [31:0] alu, input logic [EXMEM_TID_W-1:0] tid);
        exmem_pkt_t p;
        p           = '0;
        p.alu       = alu;
        p.opcode    = alu[6:0];
        p.cond      = alu[0];
        p.instr     = ~alu;
        p.reg_dst   = alu[4:0];
        p.reg2      = alu ^ 32'hA5A5_5A5A;
        p.mem_write = alu[1];
        p.alu_write = alu[2];
        p.cmd_type  = alu[3:2];
        p.tid       = tid;
        return p;
    endfunction

    // Apply one clock edge's worth of behaviour to the model, from current inputs.
    task automatic model_edge();
        exmem_pkt_t nq[$];
        bit         ready;
        if (rst) begin
            m_q.delete();
            m_drops = 0;
            m_last  = '0;
            return;
        end
        ready = (m_q.size() < 2);
        for (int i = 0; i < m_q.size(); i++) begin
            if (flush_valid && m_q[i].tid == flush_tid) m_drops++;
            else if (i == 0 && out_ready) ;   // delivered to MEM
            else nq.push_back(m_q[i]);
        end
        if (in_valid) begin
            if (flush_valid && in_pkt.tid == flush_tid) m_drops++;
            else if (ready) nq.push_back(in_pkt);
        end
        m_q = nq;
        if (m_q.size() > 0) m_last = m_q[0];
    endtask

    task automatic check_outputs();
        int exp_drop16, exp_drop2;
        exp_drop16 = (m_drops > 65535) ? 65535 : m_drops;
        exp_drop2  = (m_drops > 3) ? 3 : m_drops;
        check("occupancy",  occupancy,  m_q.size());
        check("out_valid",  out_valid,  m_q.size() > 0);
        check("in_ready",   in_ready,   m_q.size() < 2);
        check("out_pkt",    out_pkt,    m_last);
        check("drop_count", drop_count, exp_drop16);
        check("sat_occupancy",  occupancy_s,  m_q.size());
        check("sat_out_pkt",    out_pkt_s,    m_last);
        check("sat_drop_count", drop_count_s, exp_drop2);
    endtask

    // Inputs are set between edges; outputs are sampled on the falling edge.
    task automatic tick();
        if (!rst && out_valid && out_ready) out_beats++;
        model_edge();
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle();
        in_valid    = 1'b0;
        in_pkt      = '0;
        flush_valid = 1'b0;
        flush_tid   = '0;
        out_ready   = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        tick();
        tick();
        check("reset_out_pkt_zero", out_pkt, 0);
        rst = 1'b0;

        // Single beat: visible one edge after acceptance.
        in_valid = 1'b1;
        in_pkt   = mk(32'h1234_5678, 2'd1);
        tick();
        in_valid = 1'b0;
        check("single_out_valid", out_valid, 1);
        check("single_alu", out_pkt.alu, 32'h1234_5678);
        check("single_occ", occupancy, 1);
        out_ready = 1'b1;
        tick();

        // Ten back-to-back beats with MEM always ready.
        out_beats = 0;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_pkt   = mk(32'h100 + i, 2'(i));
            tick();
            check("stream_in_ready", in_ready, 1);
            check("stream_occ_not_full", occupancy != 2'd2, 1);
        end
        in_valid = 1'b0;
        tick();
        check("stream_beats_out", out_beats, 10);
        out_ready = 1'b0;

        // Backpressure: two accepted, third held off until a slot frees.
        in_valid = 1'b1;
        in_pkt   = mk(32'hA0, 2'd0);
        tick();
        in_pkt   = mk(32'hB0, 2'd1);
        tick();
        in_pkt   = mk(32'hC0, 2'd2);
        check("bp_in_ready_low", in_ready, 0);
        check("bp_occ_full", occupancy, 2);
        tick();
        check("bp_still_a", out_pkt.alu, 32'hA0);
        out_ready = 1'b1;
        tick();
        check("bp_then_b", out_pkt.alu, 32'hB0);
        check("bp_ready_back", in_ready, 1);
        tick();
        in_valid = 1'b0;
        check("bp_then_c", out_pkt.alu, 32'hC0);
        tick();
        check("bp_drained", occupancy, 0);
        out_ready = 1'b0;

        // Flush of main only: skid slides forward.
        in_valid = 1'b1;
        in_pkt   = mk(32'h29A, 2'd2);
        tick();
        in_pkt   = mk(32'h29B, 2'd3);
        tick();
        in_valid    = 1'b0;
        flush_valid = 1'b1;
        flush_tid   = 2'd2;
        tick();
        flush_valid = 1'b0;
        check("flush_main_tid", out_pkt.tid, 2'd3);
        check("flush_main_alu", out_pkt.alu, 32'h29B);
        check("flush_main_occ", occupancy, 1);
        check("flush_main_drops", drop_count, 16'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Flush kills main, skid and the offered beat in one edge.
        in_valid = 1'b1;
        in_pkt   = mk(32'h30A, 2'd0);
        tick();
        in_pkt   = mk(32'h30B, 2'd0);
        tick();
        in_pkt      = mk(32'h30C, 2'd0);
        flush_valid = 1'b1;
        flush_tid   = 2'd0;
        tick();
        idle();
        check("flush3_occ", occupancy, 0);
        check("flush3_out_valid", out_valid, 0);
        check("flush3_drops", drop_count, 16'd4);
        check("flush3_sat_drops", drop_count_s, 2'd3);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            in_valid    = ($urandom_range(0, 3) != 0);
            in_pkt      = mk($urandom, 2'($urandom_range(0, 3)));
            out_ready   = ($urandom_range(0, 2) != 0);
            flush_valid = ($urandom_range(0, 7) == 0);
            flush_tid   = 2'($urandom_range(0, 3));
            tick();
        end
        idle();
        tick();

        // Reset while FULL beats a simultaneous flush, push and pop.
        in_valid = 1'b1;
        in_pkt   = mk(32'h31A, 2'd1);
        tick();
        in_pkt   = mk(32'h31B, 2'd1);
        tick();
        check("pre_reset_full", occupancy, 2);
        rst         = 1'b1;
        in_pkt      = mk(32'h31C, 2'd1);
        flush_valid = 1'b1;
        flush_tid   = 2'd1;
        out_ready   = 1'b1;
        tick();
        check("rst_occ", occupancy, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_drops", drop_count, 0);
        check("rst_out_pkt", out_pkt, 0);
        check("rst_skid", dut.r_skid, 0);
        rst = 1'b0;
        idle();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
